// File: rtl/gpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// gpu_pkg : shared types and defaults for the block dispatcher
// rev 1.0
// ---------------------------------------------------------------
package gpu_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      WAIT     = 2'd2,
      DONE     = 2'd3
   } dispatch_state_t;

   localparam int DEF_THREADS_PER_BLOCK = 4;
   localparam int DEF_NUM_CORES         = 2;
   localparam int DEF_CNT_W             = 8;

   // A single core still needs a one-bit index field.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/block_dispatcher_free_core_picker.sv
`default_nettype none
// ---------------------------------------------------------------
// free_core_picker : lowest-index free core priority encoder
// rev 1.0
// ---------------------------------------------------------------
module free_core_picker
   import gpu_pkg::*;
#(
   parameter  int NUM_CORES = DEF_NUM_CORES,
   localparam int IDX_W     = idx_width(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] core_busy,
   output logic                 valid,
   output logic [IDX_W-1:0]     idx
);

   // Scan from the top so the lowest free index is the last one written.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (!core_busy[i]) begin
            valid = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/block_dispatcher.sv
`default_nettype none
// ---------------------------------------------------------------
// block_dispatcher : splits a kernel into blocks, feeds cores, tracks retirement
// rev 1.0
// ---------------------------------------------------------------
module block_dispatcher
   import gpu_pkg::*;
#(
   parameter  int NUM_CORES         = DEF_NUM_CORES,
   parameter  int THREADS_PER_BLOCK = DEF_THREADS_PER_BLOCK,
   parameter  int CNT_W             = DEF_CNT_W,
   localparam int TW                = $clog2(THREADS_PER_BLOCK) + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [CNT_W-1:0]           thread_count,
   input  logic [NUM_CORES-1:0]       core_done,
   output logic [NUM_CORES-1:0]       core_start,
   output logic [NUM_CORES*CNT_W-1:0] core_block_id,
   output logic [NUM_CORES*TW-1:0]    core_block_threads,
   output logic                       busy,
   output logic                       done
);

   localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
   localparam int IDX_W    = idx_width(NUM_CORES);
   localparam int BLK_W    = CNT_W + 1;

   dispatch_state_t             state_q, state_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic [BLK_W-1:0]            total_q, total_d;
   logic [BLK_W-1:0]            dispatched_q, dispatched_d;
   logic [BLK_W-1:0]            retired_q, retired_d;
   logic [NUM_CORES-1:0]        core_busy_q, core_busy_d;
   logic [NUM_CORES-1:0]        core_start_q, core_start_d;
   logic [NUM_CORES*CNT_W-1:0]  block_id_q, block_id_d;
   logic [NUM_CORES*TW-1:0]     threads_q, threads_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;

   logic                        pick_valid;
   logic [IDX_W-1:0]            pick_idx;
   logic                        dispatch_en;
   logic                        last_block;
   logic [CNT_W-1:0]            remainder;
   logic [TW-1:0]               blk_threads;
   logic [BLK_W-1:0]            launch_blocks;

   free_core_picker #(
      .NUM_CORES (NUM_CORES)
   ) u_picker (
      .core_busy (core_busy_q),
      .valid     (pick_valid),
      .idx       (pick_idx)
   );

   // One extra bit keeps a full-range thread_count from wrapping.
   assign launch_blocks = ({1'b0, thread_count} + BLK_W'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB;

   assign dispatch_en = (state_q == DISPATCH) && (dispatched_q < total_q) && pick_valid;
   assign last_block  = (dispatched_q == total_q - BLK_W'(1));
   assign remainder   = count_q & CNT_W'(THREADS_PER_BLOCK - 1);
   assign blk_threads = (last_block && (remainder != '0)) ? TW'(remainder)
                                                          : TW'(THREADS_PER_BLOCK);

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      total_d      = total_q;
      dispatched_d = dispatched_q;
      retired_d    = retired_q;
      core_busy_d  = core_busy_q;
      core_start_d = '0;
      block_id_d   = block_id_q;
      threads_d    = threads_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (thread_count != '0) begin
                  count_d      = thread_count;
                  total_d      = launch_blocks;
                  dispatched_d = '0;
                  retired_d    = '0;
                  core_busy_d  = '0;
                  state_d      = DISPATCH;
               end else begin
                  state_d      = DONE;
               end
            end
         end

         DISPATCH, WAIT: begin
            if (dispatch_en) begin
               dispatched_d = dispatched_q + BLK_W'(1);
            end
            // Retirement is judged against the busy mask seen at the start of the
            // cycle, so a freshly dispatched core can never be retired in the same cycle.
            for (int i = 0; i < NUM_CORES; i++) begin
               if (dispatch_en && (pick_idx == IDX_W'(i))) begin
                  core_start_d[i]                = 1'b1;
                  core_busy_d[i]                 = 1'b1;
                  block_id_d[i*CNT_W +: CNT_W]   = dispatched_q[CNT_W-1:0];
                  threads_d[i*TW +: TW]          = blk_threads;
               end
               if (core_done[i] && core_busy_q[i]) begin
                  core_busy_d[i] = 1'b0;
                  retired_d      = retired_d + BLK_W'(1);
               end
            end
            if (dispatched_d == total_q) begin
               state_d = (retired_d == total_q) ? DONE : WAIT;
            end
         end

         DONE: begin
            if (!start) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d == DISPATCH) || (state_d == WAIT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         count_q      <= '0;
         total_q      <= '0;
         dispatched_q <= '0;
         retired_q    <= '0;
         core_busy_q  <= '0;
         core_start_q <= '0;
         block_id_q   <= '0;
         threads_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         total_q      <= total_d;
         dispatched_q <= dispatched_d;
         retired_q    <= retired_d;
         core_busy_q  <= core_busy_d;
         core_start_q <= core_start_d;
         block_id_q   <= block_id_d;
         threads_q    <= threads_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign core_start         = core_start_q;
   assign core_block_id      = block_id_q;
   assign core_block_threads = threads_q;
   assign busy               = busy_q;
   assign done               = done_q;

endmodule
`default_nettype wire
